// File: rtl/ext_entry_arbiter_pkg.sv
// Shared FSM encoding, default widths and sizing helper for the external entry arbiter.
package ext_entry_arbiter_pkg;

  localparam int unsigned DEF_ARG_WIDTH = 32;
  localparam int unsigned DEF_RES_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    DELIVER  = 2'd3
  } arb_state_e;

  // Width of a client index; a single client still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ext_entry_arbiter_if.sv
// Client-side and downstream-entry handshake bundle of the external entry arbiter.
interface ext_entry_arbiter_if
  import ext_entry_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned ARG_WIDTH   = DEF_ARG_WIDTH,
  parameter int unsigned RES_WIDTH   = DEF_RES_WIDTH
);

  logic [NUM_CLIENTS-1:0]           c_req_valid;
  logic [NUM_CLIENTS-1:0]           c_req_ready;
  logic [NUM_CLIENTS*ARG_WIDTH-1:0] c_req_0;
  logic [NUM_CLIENTS*ARG_WIDTH-1:0] c_req_1;
  logic [NUM_CLIENTS-1:0]           c_res_valid;
  logic [NUM_CLIENTS-1:0]           c_res_ready;
  logic [RES_WIDTH-1:0]             c_res_0;

  logic                             f_req_valid;
  logic                             f_req_ready;
  logic                             f_req_busy;
  logic [ARG_WIDTH-1:0]             f_req_0;
  logic [ARG_WIDTH-1:0]             f_req_1;
  logic                             f_res_valid;
  logic                             f_res_ready;
  logic [RES_WIDTH-1:0]             f_res_0;

  // Arbiter side
  modport slave (
    input  c_req_valid, c_req_0, c_req_1, c_res_ready,
           f_req_ready, f_req_busy, f_res_valid, f_res_0,
    output c_req_ready, c_res_valid, c_res_0,
           f_req_valid, f_req_0, f_req_1, f_res_ready
  );

  // Clients plus downstream entry, seen from outside the arbiter
  modport master (
    output c_req_valid, c_req_0, c_req_1, c_res_ready,
           f_req_ready, f_req_busy, f_res_valid, f_res_0,
    input  c_req_ready, c_res_valid, c_res_0,
           f_req_valid, f_req_0, f_req_1, f_res_ready
  );

endinterface

// File: rtl/ext_entry_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requester after last_grant, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned IDX_W       = 2
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [NUM_CLIENTS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx
);

  logic [IDX_W-1:0] cand;

  // Scan from lowest to highest priority so the closest requester after last_grant wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = NUM_CLIENTS; k >= 1; k--) begin
      cand = IDX_W'((32'(last_grant) + k) % NUM_CLIENTS);
      if (req[cand]) begin
        grant     = NUM_CLIENTS'(1) << cand;
        grant_idx = cand;
      end
    end
  end

endmodule

// File: rtl/ext_entry_arbiter.sv
// Shares one downstream external entry among NUM_CLIENTS requesters, one call in flight.
module ext_entry_arbiter
  import ext_entry_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned ARG_WIDTH   = DEF_ARG_WIDTH,
  parameter int unsigned RES_WIDTH   = DEF_RES_WIDTH
) (
  input logic              clk,
  input logic              rst,
  ext_entry_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(NUM_CLIENTS);

  arb_state_e             state;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       gnt_idx;
  logic [NUM_CLIENTS-1:0] gnt_oh;

  logic [NUM_CLIENTS-1:0] req_ready_q;
  logic [NUM_CLIENTS-1:0] res_valid_q;
  logic [RES_WIDTH-1:0]   res_q;
  logic                   f_req_valid_q;
  logic                   f_res_ready_q;
  logic [ARG_WIDTH-1:0]   f_arg0_q;
  logic [ARG_WIDTH-1:0]   f_arg1_q;

  logic [NUM_CLIENTS-1:0] sel_oh_c;
  logic [IDX_W-1:0]       sel_idx_c;
  logic [ARG_WIDTH-1:0]   sel_arg0_c;
  logic [ARG_WIDTH-1:0]   sel_arg1_c;
  logic                   start_c;

  rr_arbiter #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_rr_arbiter (
    .req        (bus.c_req_valid),
    .last_grant (last_grant),
    .grant      (sel_oh_c),
    .grant_idx  (sel_idx_c)
  );

  // Argument mux steered by the one-hot pick.
  always_comb begin
    sel_arg0_c = '0;
    sel_arg1_c = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (sel_oh_c[i]) begin
        sel_arg0_c = bus.c_req_0[i*ARG_WIDTH +: ARG_WIDTH];
        sel_arg1_c = bus.c_req_1[i*ARG_WIDTH +: ARG_WIDTH];
      end
    end
  end

  assign start_c = (state == IDLE) && (|bus.c_req_valid) && !bus.f_req_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= IDX_W'(NUM_CLIENTS - 1);
      gnt_idx       <= '0;
      gnt_oh        <= '0;
      req_ready_q   <= '0;
      res_valid_q   <= '0;
      res_q         <= '0;
      f_req_valid_q <= 1'b0;
      f_res_ready_q <= 1'b0;
      f_arg0_q      <= '0;
      f_arg1_q      <= '0;
    end else begin
      // Acceptance is a single-cycle pulse.
      req_ready_q <= '0;
      case (state)
        IDLE: begin
          if (start_c) begin
            gnt_idx       <= sel_idx_c;
            gnt_oh        <= sel_oh_c;
            req_ready_q   <= sel_oh_c;
            f_arg0_q      <= sel_arg0_c;
            f_arg1_q      <= sel_arg1_c;
            f_req_valid_q <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.f_req_ready) begin
            f_req_valid_q <= 1'b0;
            f_res_ready_q <= 1'b1;
            state         <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (bus.f_res_valid) begin
            res_q         <= bus.f_res_0;
            f_res_ready_q <= 1'b0;
            res_valid_q   <= gnt_oh;
            state         <= DELIVER;
          end
        end
        DELIVER: begin
          // Only the grantee's accept completes the call.
          if (|(bus.c_res_ready & gnt_oh)) begin
            res_valid_q <= '0;
            last_grant  <= gnt_idx;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.c_req_ready = req_ready_q;
  assign bus.c_res_valid = res_valid_q;
  assign bus.c_res_0     = res_q;
  assign bus.f_req_valid = f_req_valid_q;
  assign bus.f_req_0     = f_arg0_q;
  assign bus.f_req_1     = f_arg1_q;
  assign bus.f_res_ready = f_res_ready_q;

endmodule
